// File: rtl/pad_mux_ctrl_if.sv
// pad_mux_ctrl configuration bus.
// One request per cycle, one response strobe a cycle later.
interface pad_mux_ctrl_if;
  logic       cfg_req_i;
  logic       cfg_we_i;
  logic [9:0] cfg_addr_i;
  logic [7:0] cfg_wdata_i;
  logic       cfg_rvalid_o;
  logic [7:0] cfg_rdata_o;
  logic       cfg_err_o;

  modport master (
    output cfg_req_i,
    output cfg_we_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    input  cfg_rvalid_o,
    input  cfg_rdata_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_req_i,
    input  cfg_we_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    output cfg_rvalid_o,
    output cfg_rdata_o,
    output cfg_err_o
  );
endinterface

// File: rtl/pad_mux_ctrl.sv
// pad_mux_ctrl: lockable pad/peripheral pin multiplexer.
// Define PAD_MUX_INPUT_FILTER_EN to add a per-pad input glitch filter.
module pad_mux_ctrl #(
  parameter int NPads = 59,
  parameter int NPeriOut = 40,
  parameter int NPeriIn = 16,
  parameter logic [NPeriIn-1:0] InDefault = '0,
  parameter int FilterCycles = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pad_mux_ctrl_if.slave       cfg,
  input  logic [NPeriOut-1:0] peri_out_i,
  input  logic [NPeriOut-1:0] peri_oe_i,
  output logic [NPeriIn-1:0]  peri_in_o,
  input  logic [NPads-1:0]    pad_in_i,
  output logic [NPads-1:0]    pad_out_o,
  output logic [NPads-1:0]    pad_oe_o,
  output logic                locked_o
);

  localparam logic [8:0] NPadsL = 9'(NPads);
  localparam logic [8:0] NOutL = 9'(NPeriOut);
  localparam logic [8:0] NInL = 9'(NPeriIn);

  logic [7:0] out_sel [NPads];
  logic [7:0] in_sel [NPeriIn];
  logic       lock_q;

  logic [1:0] bank;
  logic [7:0] idx;
  logic       addr_ok;
  logic       val_ok;
  logic [7:0] rd_val;
  logic       err_c;
  logic       wr_out;
  logic       wr_in;
  logic       wr_lock;

  logic [NPads-1:0] sync1;
  logic [NPads-1:0] sync2;
  logic [NPads-1:0] cond;

  logic [255:0] out_ext;
  logic [255:0] oe_ext;
  logic [255:0] in_ext;

  assign bank = cfg.cfg_addr_i[9:8];
  assign idx = cfg.cfg_addr_i[7:0];
  assign locked_o = lock_q;

  // Decode address, check value range and fetch read data.
  always_comb begin
    addr_ok = 1'b0;
    val_ok = 1'b0;
    rd_val = '0;
    unique case (bank)
      2'd0: begin
        addr_ok = {1'b0, idx} < NPadsL;
        val_ok = {1'b0, cfg.cfg_wdata_i} <= NOutL;
        for (int p = 0; p < NPads; p++) begin
          if (idx == 8'(p)) rd_val = out_sel[p];
        end
      end
      2'd1: begin
        addr_ok = {1'b0, idx} < NInL;
        val_ok = {1'b0, cfg.cfg_wdata_i} <= NPadsL;
        for (int i = 0; i < NPeriIn; i++) begin
          if (idx == 8'(i)) rd_val = in_sel[i];
        end
      end
      2'd2: begin
        addr_ok = idx == 8'd0;
        val_ok = 1'b1;
        rd_val = {7'd0, lock_q};
      end
      default: begin
        addr_ok = 1'b0;
        val_ok = 1'b0;
        rd_val = '0;
      end
    endcase
    err_c = !addr_ok
          || (cfg.cfg_we_i && (lock_q || !val_ok));
    wr_out = cfg.cfg_req_i && cfg.cfg_we_i
           && !err_c && bank == 2'd0;
    wr_in = cfg.cfg_req_i && cfg.cfg_we_i
          && !err_c && bank == 2'd1;
    wr_lock = cfg.cfg_req_i && cfg.cfg_we_i
            && !err_c && bank == 2'd2;
  end

  // Select registers and lock; illegal accesses leave them untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NPads; p++) out_sel[p] <= '0;
      for (int i = 0; i < NPeriIn; i++) in_sel[i] <= '0;
      lock_q <= 1'b0;
    end else begin
      for (int p = 0; p < NPads; p++) begin
        if (wr_out && idx == 8'(p)) out_sel[p] <= cfg.cfg_wdata_i;
      end
      for (int i = 0; i < NPeriIn; i++) begin
        if (wr_in && idx == 8'(i)) in_sel[i] <= cfg.cfg_wdata_i;
      end
      if (wr_lock && cfg.cfg_wdata_i[0]) lock_q <= 1'b1;
    end
  end

  // Registered response: one strobe per request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg.cfg_rvalid_o <= 1'b0;
      cfg.cfg_err_o <= 1'b0;
      cfg.cfg_rdata_o <= '0;
    end else begin
      cfg.cfg_rvalid_o <= cfg.cfg_req_i;
      cfg.cfg_err_o <= cfg.cfg_req_i && err_c;
      cfg.cfg_rdata_o <= (cfg.cfg_req_i && !cfg.cfg_we_i && !err_c)
                       ? rd_val : '0;
    end
  end

  // Two-flop synchroniser on every pad input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_in_i;
      sync2 <= sync1;
    end
  end

`ifdef PAD_MUX_INPUT_FILTER_EN
  localparam logic [7:0] FcM1 = 8'(FilterCycles - 1);

  logic [NPads-1:0] filt;
  logic [7:0]       cnt [NPads];

  assign cond = filt;

  // Accept a new level only after FilterCycles differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt <= '0;
      for (int p = 0; p < NPads; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPads; p++) begin
        if (sync2[p] == filt[p]) begin
          cnt[p] <= '0;
        end else if (cnt[p] == FcM1) begin
          filt[p] <= sync2[p];
          cnt[p] <= '0;
        end else begin
          cnt[p] <= cnt[p] + 8'd1;
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

  // Bit 0 of each extended vector is the "unmapped" slot.
  assign out_ext = 256'({peri_out_i, 1'b0});
  assign oe_ext = 256'({peri_oe_i, 1'b0});
  assign in_ext = 256'({cond, 1'b0});

  // Pad drive from the selected peripheral output.
  always_comb begin
    pad_out_o = '0;
    pad_oe_o = '0;
    for (int p = 0; p < NPads; p++) begin
      pad_out_o[p] = out_ext[out_sel[p]];
      pad_oe_o[p] = oe_ext[out_sel[p]];
    end
  end

  // Peripheral inputs from the selected conditioned pad.
  always_comb begin
    peri_in_o = '0;
    for (int i = 0; i < NPeriIn; i++) begin
      peri_in_o[i] = (in_sel[i] == 8'd0)
                   ? InDefault[i] : in_ext[in_sel[i]];
    end
  end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Testbench for pad_mux_ctrl.
// Vector table, random traffic against a reference model, corner cases.
module tb_pad_mux_ctrl;
  localparam int NPads = 59;
  localparam int NOut = 40;
  localparam int NIn = 16;
`ifdef PAD_MUX_INPUT_FILTER_EN
  localparam int Lat = 6;
  localparam int Hold = 10;
`else
  localparam int Lat = 2;
  localparam int Hold = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NOut-1:0] peri_out = '0;
  logic [NOut-1:0] peri_oe = '0;
  logic [NIn-1:0] peri_in;
  logic [NPads-1:0] pad_in = '0;
  logic [NPads-1:0] pad_out;
  logic [NPads-1:0] pad_oe;
  logic locked;

  pad_mux_ctrl_if cfg_if ();

  pad_mux_ctrl dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cfg(cfg_if.slave),
    .peri_out_i(peri_out),
    .peri_oe_i(peri_oe),
    .peri_in_o(peri_in),
    .pad_in_i(pad_in),
    .pad_out_o(pad_out),
    .pad_oe_o(pad_oe),
    .locked_o(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  int m_out [NPads];
  int m_in [NIn];
  bit m_lock;
  logic [NPads-1:0] hist [$];

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply one access to the model, return expected response.
  task automatic model_access(input logic we, input logic [9:0] addr,
                              input logic [7:0] wd, output logic err,
                              output logic [7:0] rd);
    int bank, idx, v;
    bit ok, in_range;
    bank = int'(addr) / 256;
    idx = int'(addr) % 256;
    v = int'(wd);
    ok = 0;
    in_range = 0;
    rd = 0;
    if (bank == 0) begin
      ok = idx < NPads;
      in_range = v <= NOut;
      if (ok) rd = 8'(m_out[idx]);
    end else if (bank == 1) begin
      ok = idx < NIn;
      in_range = v <= NPads;
      if (ok) rd = 8'(m_in[idx]);
    end else if (bank == 2) begin
      ok = idx == 0;
      in_range = 1;
      rd = 8'(m_lock);
    end
    err = !ok || (we && (m_lock || !in_range));
    if (err || we) rd = 0;
    if (we && !err) begin
      if (bank == 0) m_out[idx] = v;
      if (bank == 1) m_in[idx] = v;
      if (bank == 2 && wd[0]) m_lock = 1;
    end
  endtask

  task automatic model_clear();
    foreach (m_out[p]) m_out[p] = 0;
    foreach (m_in[i]) m_in[i] = 0;
    m_lock = 0;
  endtask

  function automatic logic [NPads-1:0] exp_pad_out();
    logic [NPads-1:0] r;
    r = '0;
    for (int p = 0; p < NPads; p++)
      if (m_out[p] != 0) r[p] = peri_out[m_out[p]-1];
    return r;
  endfunction

  function automatic logic [NPads-1:0] exp_pad_oe();
    logic [NPads-1:0] r;
    r = '0;
    for (int p = 0; p < NPads; p++)
      if (m_out[p] != 0) r[p] = peri_oe[m_out[p]-1];
    return r;
  endfunction

  function automatic logic [NIn-1:0] exp_peri_in(
      input logic [NPads-1:0] src);
    logic [NIn-1:0] r;
    r = '0;
    for (int i = 0; i < NIn; i++)
      if (m_in[i] != 0) r[i] = src[m_in[i]-1];
    return r;
  endfunction

  task automatic do_cfg(input logic we, input logic [9:0] a,
                        input logic [7:0] d);
    cfg_if.cfg_req_i = 1'b1;
    cfg_if.cfg_we_i = we;
    cfg_if.cfg_addr_i = a;
    cfg_if.cfg_wdata_i = d;
    @(posedge clk);
    #1;
    cfg_if.cfg_req_i = 1'b0;
    cfg_if.cfg_we_i = 1'b0;
  endtask

  task automatic rand_peri();
    logic [63:0] t;
    t = {$urandom, $urandom};
    peri_out = t[NOut-1:0];
    t = {$urandom, $urandom};
    peri_oe = t[NOut-1:0];
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic e;
    logic [7:0] rd;
    logic [63:0] t;
    logic [NPads-1:0] pend;
    bit saw;
    cfg_if.cfg_req_i = 1'b0;
    cfg_if.cfg_we_i = 1'b0;
    cfg_if.cfg_addr_i = '0;
    cfg_if.cfg_wdata_i = '0;
    model_clear();

    tbl[0]  = '{1'b1, 10'h005, 8'd3,  1'b0, 8'd0};
    tbl[1]  = '{1'b0, 10'h005, 8'd0,  1'b0, 8'd3};
    tbl[2]  = '{1'b1, 10'h101, 8'd10, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 10'h101, 8'd0,  1'b0, 8'd10};
    tbl[4]  = '{1'b1, 10'h005, 8'd41, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 10'h005, 8'd0,  1'b0, 8'd3};
    tbl[6]  = '{1'b1, 10'h03B, 8'd1,  1'b1, 8'd0};
    tbl[7]  = '{1'b0, 10'h03B, 8'd0,  1'b1, 8'd0};
    tbl[8]  = '{1'b1, 10'h03A, 8'd40, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 10'h03A, 8'd0,  1'b0, 8'd40};
    tbl[10] = '{1'b1, 10'h110, 8'd1,  1'b1, 8'd0};
    tbl[11] = '{1'b1, 10'h10F, 8'd59, 1'b0, 8'd0};
    tbl[12] = '{1'b1, 10'h10F, 8'd60, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 10'h10F, 8'd0,  1'b0, 8'd59};
    tbl[14] = '{1'b0, 10'h201, 8'd0,  1'b1, 8'd0};
    tbl[15] = '{1'b0, 10'h300, 8'd0,  1'b1, 8'd0};

    // Outputs while held in reset with busy inputs.
    rand_peri();
    t = {$urandom, $urandom};
    pad_in = t[NPads-1:0];
    cycles(4);
    chk("rst_pad_oe", 64'(pad_oe), 0);
    chk("rst_pad_out", 64'(pad_out), 0);
    chk("rst_peri_in", 64'(peri_in), 0);
    chk("rst_locked", 64'(locked), 0);
    chk("rst_rvalid", 64'(cfg_if.cfg_rvalid_o), 0);
    pad_in = '0;
    rst_n = 1'b1;
    cycles(2);

    // Table-driven register accesses.
    for (int k = 0; k < 16; k++) begin
      model_access(tbl[k].we, tbl[k].addr, tbl[k].wdata, e, rd);
      do_cfg(tbl[k].we, tbl[k].addr, tbl[k].wdata);
      chk($sformatf("tbl%0d_rvalid", k), 64'(cfg_if.cfg_rvalid_o), 1);
      chk($sformatf("tbl%0d_err", k), 64'(cfg_if.cfg_err_o),
          64'(tbl[k].err));
      chk($sformatf("tbl%0d_rdata", k), 64'(cfg_if.cfg_rdata_o),
          64'(tbl[k].rdata));
    end
    cycles(1);
    chk("idle_rvalid", 64'(cfg_if.cfg_rvalid_o), 0);

    // Pad 5 follows peripheral output 2.
    for (int k = 0; k < 3; k++) begin
      rand_peri();
      #1;
      chk("pad5_out", 64'(pad_out[5]), 64'(peri_out[2]));
      chk("pad5_oe", 64'(pad_oe[5]), 64'(peri_oe[2]));
      chk("pad58_out", 64'(pad_out[58]), 64'(peri_out[39]));
    end

    // Random traffic against the reference model.
    hist.delete();
    for (int k = 0; k < Lat; k++) hist.push_front(pad_in);
    pend = pad_in;
    for (int n = 0; n < 1500; n++) begin
      logic we;
      logic [9:0] a;
      logic [7:0] d;
      int bank, idx;
      logic req;
      rand_peri();
      if (n % Hold == 0) begin
        t = {$urandom, $urandom};
        pend = t[NPads-1:0];
      end
      pad_in = pend;
      req = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 1);
      bank = $urandom_range(0, 3);
      case (bank)
        0: begin idx = $urandom_range(0, 62); d = 8'($urandom_range(0, 43)); end
        1: begin idx = $urandom_range(0, 18); d = 8'($urandom_range(0, 62)); end
        2: begin idx = $urandom_range(0, 1); d = 8'($urandom_range(0, 255)); end
        default: begin idx = $urandom_range(0, 255); d = 8'($urandom); end
      endcase
      if (bank == 2) d[0] = 1'b0;
      a = 10'(bank * 256 + idx);
      e = 0;
      rd = 0;
      if (req) model_access(we, a, d, e, rd);
      cfg_if.cfg_req_i = req;
      cfg_if.cfg_we_i = we;
      cfg_if.cfg_addr_i = a;
      cfg_if.cfg_wdata_i = d;
      hist.push_front(pad_in);
      if (hist.size() > Lat) void'(hist.pop_back());
      @(posedge clk);
      #1;
      chk("rnd_rvalid", 64'(cfg_if.cfg_rvalid_o), 64'(req));
      chk("rnd_err", 64'(cfg_if.cfg_err_o), 64'(e));
      chk("rnd_rdata", 64'(cfg_if.cfg_rdata_o), 64'(rd));
      chk("rnd_pad_out", 64'(pad_out), 64'(exp_pad_out()));
      chk("rnd_pad_oe", 64'(pad_oe), 64'(exp_pad_oe()));
      chk("rnd_peri_in", 64'(peri_in),
          64'(exp_peri_in(hist[Lat-1])));
      chk("rnd_locked", 64'(locked), 0);
    end
    cfg_if.cfg_req_i = 1'b0;

    // Reset asserted in the middle of a read.
    pad_in = '1;
    cycles(Lat + 4);
    cfg_if.cfg_req_i = 1'b1;
    cfg_if.cfg_we_i = 1'b0;
    cfg_if.cfg_addr_i = 10'h000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid", 64'(cfg_if.cfg_rvalid_o), 0);
    chk("mid_rdata", 64'(cfg_if.cfg_rdata_o), 0);
    chk("mid_err", 64'(cfg_if.cfg_err_o), 0);
    chk("mid_pad_oe", 64'(pad_oe), 0);
    chk("mid_pad_out", 64'(pad_out), 0);
    chk("mid_peri_in", 64'(peri_in), 0);
    cfg_if.cfg_req_i = 1'b0;
    pad_in = '0;
    model_clear();
    cycles(2);
    rst_n = 1'b1;
    cycles(Lat + 2);

    // Pad 9 to peripheral input 1 latency.
    do_cfg(1'b1, 10'h101, 8'd10);
    chk("lat_map_err", 64'(cfg_if.cfg_err_o), 0);
    cycles(2);
    pad_in[9] = 1'b1;
    cycles(Lat - 1);
    chk("lat_before", 64'(peri_in[1]), 0);
    cycles(1);
    chk("lat_at", 64'(peri_in[1]), 1);
    pad_in[9] = 1'b0;
    cycles(Lat + 4);
    chk("lat_fall", 64'(peri_in[1]), 0);

    // Short pulse: dropped by the filter, passed straight through otherwise.
    saw = 0;
`ifdef PAD_MUX_INPUT_FILTER_EN
    pad_in[9] = 1'b1;
    cycles(3);
    pad_in[9] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      if (peri_in[1]) saw = 1;
    end
    chk("pulse_suppressed", 64'(saw), 0);
`else
    pad_in[9] = 1'b1;
    cycles(1);
    pad_in[9] = 1'b0;
    cycles(1);
    chk("pulse_seen", 64'(peri_in[1]), 1);
    cycles(1);
    chk("pulse_gone", 64'(peri_in[1]), 0);
`endif

    // Lock, refused write, legal read, cleared by reset.
    do_cfg(1'b1, 10'h005, 8'd3);
    do_cfg(1'b1, 10'h200, 8'd1);
    chk("lock_wr_err", 64'(cfg_if.cfg_err_o), 0);
    chk("lock_locked", 64'(locked), 1);
    do_cfg(1'b1, 10'h005, 8'd0);
    chk("lock_wr_refused", 64'(cfg_if.cfg_err_o), 1);
    do_cfg(1'b0, 10'h005, 8'd0);
    chk("lock_rd_err", 64'(cfg_if.cfg_err_o), 0);
    chk("lock_rd_data", 64'(cfg_if.cfg_rdata_o), 3);
    do_cfg(1'b0, 10'h200, 8'd0);
    chk("lock_reg_rd", 64'(cfg_if.cfg_rdata_o), 1);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    chk("unlock_after_rst", 64'(locked), 0);
    do_cfg(1'b0, 10'h005, 8'd0);
    chk("rd_after_rst", 64'(cfg_if.cfg_rdata_o), 0);
    chk("rd_after_rst_err", 64'(cfg_if.cfg_err_o), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
